// File: rtl/cordic_angle_sequencer_pkg.sv
// Shared constants, FSM state encoding and result payload for the CORDIC angle sequencer.
// Angles in Q3.16 (input) and Q2.16 (reduced angle, cos/sin).
package cordic_angle_sequencer_pkg;

   localparam int unsigned Q_FRAC     = 16;
   localparam int unsigned ANGLE_IN_W = 19;
   localparam int unsigned DATA_W     = 18;
   localparam int          PI_Q       = 205887;
   localparam int          HALF_PI_Q  = 102944;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DRAIN = 3'd2,
      ST_BUSY  = 3'd3,
      ST_HOLD  = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] cos_v;
      logic signed [DATA_W-1:0] sin_v;
   } trig_t;

   localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Two's-complement negate that maps the most negative code to the most positive one.
   function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W-1:0] r;
      if (x == DATA_MIN) r = DATA_MAX;
      else               r = -x;
      return r;
   endfunction

endpackage

// File: rtl/cordic_angle_sequencer_quadrant_map.sv
// Combinational clamp to [-pi, pi] and fold into [-pi/2, pi/2] with a cos/sin negate flag.
module cordic_angle_sequencer_quadrant_map
   import cordic_angle_sequencer_pkg::*;
(
   input  logic signed [ANGLE_IN_W-1:0] angle,
   output logic signed [DATA_W-1:0]     reduced,
   output logic                         neg
);

   localparam logic signed [ANGLE_IN_W-1:0] PI_S       = ANGLE_IN_W'(PI_Q);
   localparam logic signed [ANGLE_IN_W-1:0] NEG_PI_S   = ANGLE_IN_W'(-PI_Q);
   localparam logic signed [ANGLE_IN_W-1:0] HALF_S     = ANGLE_IN_W'(HALF_PI_Q);
   localparam logic signed [ANGLE_IN_W-1:0] NEG_HALF_S = ANGLE_IN_W'(-HALF_PI_Q);

   logic signed [ANGLE_IN_W-1:0] clamped;
   logic signed [ANGLE_IN_W-1:0] folded;

   always_comb begin
      clamped = angle;
      if (angle > PI_S)          clamped = PI_S;
      else if (angle < NEG_PI_S) clamped = NEG_PI_S;
   end

   // A shift by pi negates both cos and sin; exactly +-pi/2 stays unfolded.
   always_comb begin
      folded = clamped;
      neg    = 1'b0;
      if (clamped > HALF_S) begin
         folded = clamped - PI_S;
         neg    = 1'b1;
      end else if (clamped < NEG_HALF_S) begin
         folded = clamped + PI_S;
         neg    = 1'b1;
      end
   end

   // Folded range is within +-pi/2, so the top bit is redundant.
   assign reduced = DATA_W'(folded);

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Front-end sequencer for the iterative CORDIC: folds the angle, runs the core, sign-corrects cos/sin.
// Optional watchdog on the CORDIC wait enabled by defining CORDIC_SEQ_TIMEOUT_EN.
module cordic_angle_sequencer
   import cordic_angle_sequencer_pkg::*;
#(
   parameter int unsigned FRAC           = Q_FRAC,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ANGLE_IN_W-1:0] in_angle,
   output logic [DATA_W-1:0]     cordic_angle,
   output logic                  cordic_init,
   input  logic                  cordic_done,
   input  logic [DATA_W-1:0]     cordic_cos,
   input  logic [DATA_W-1:0]     cordic_sin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_cos,
   output logic [DATA_W-1:0]     out_sin,
   output logic                  out_err
);

   if (FRAC != Q_FRAC || TIMEOUT_CYCLES < 2) begin : g_cfg_check
      $error("cordic_angle_sequencer: FRAC must be %0d and TIMEOUT_CYCLES at least 2", Q_FRAC);
   end

   seq_state_t               state;
   logic                     neg_q;
   trig_t                    result_q;
   trig_t                    corrected;
   logic signed [DATA_W-1:0] reduced;
   logic                     neg;
   logic                     timeout_hit;

   cordic_angle_sequencer_quadrant_map u_quadrant_map (
      .angle   (in_angle),
      .reduced (reduced),
      .neg     (neg)
   );

   always_comb begin
      corrected.cos_v = neg_q ? sat_neg(cordic_cos) : $signed(cordic_cos);
      corrected.sin_v = neg_q ? sat_neg(cordic_sin) : $signed(cordic_sin);
   end

   // Transaction FSM; in_ready, cordic_init and out_valid are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         in_ready     <= 1'b0;
         cordic_init  <= 1'b0;
         cordic_angle <= '0;
         neg_q        <= 1'b0;
         out_valid    <= 1'b0;
         result_q     <= '0;
      end else begin
         cordic_init <= 1'b0;
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  cordic_angle <= reduced;
                  neg_q        <= neg;
                  in_ready     <= 1'b0;
                  cordic_init  <= 1'b1;
                  state        <= ST_START;
               end
            end
            ST_START: begin
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (timeout_hit) begin
                  result_q  <= '0;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else if (!cordic_done) begin
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cordic_done) begin
                  result_q  <= corrected;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else if (timeout_hit) begin
                  result_q  <= '0;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_cos = result_q.cos_v;
   assign out_sin = result_q.sin_v;

`ifdef CORDIC_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent waiting on the core; a completed result in the same cycle wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else if (state == ST_START) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else if (state == ST_DRAIN || state == ST_BUSY) begin
         if (timeout_hit) begin
            if (!(state == ST_BUSY && cordic_done)) err_q <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
      end
   end

   assign out_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Scoreboard bench for cordic_angle_sequencer paired with a behavioural CORDIC model.
// Define CORDIC_SEQ_TIMEOUT_EN to also exercise the watchdog with a core that never finishes.
module tb_cordic_angle_sequencer;

   localparam int STUB_LAT = 10;
   localparam int TMO      = 64;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [18:0] in_angle  = '0;
   logic        in_ready, cordic_init, cordic_done, out_valid, out_err;
   logic [17:0] cordic_angle, cordic_cos, cordic_sin, out_cos, out_sin;

   always #5 clk = ~clk;

   cordic_angle_sequencer #(.FRAC(16), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_angle     (in_angle),
      .cordic_angle (cordic_angle),
      .cordic_init  (cordic_init),
      .cordic_done  (cordic_done),
      .cordic_cos   (cordic_cos),
      .cordic_sin   (cordic_sin),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_cos      (out_cos),
      .out_sin      (out_sin),
      .out_err      (out_err)
   );

   function automatic int sx18(input logic [17:0] v);
      int r;
      r = $signed(v);
      return r;
   endfunction

   function automatic logic [17:0] q18(input real x);
      int v;
      v = int'(x * 65536.0);
      if (v > 131071)  v = 131071;
      if (v < -131072) v = -131072;
      return 18'(v);
   endfunction

   function automatic int clamp_pi(input int v);
      if (v > 205887)  return 205887;
      if (v < -205887) return -205887;
      return v;
   endfunction

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Behavioural CORDIC: done stays high briefly after init, then results appear after STUB_LAT cycles.
   logic        stub_done  = 1'b0;
   logic [17:0] stub_cos   = '0;
   logic [17:0] stub_sin   = '0;
   logic [17:0] stub_ang   = '0;
   bit          stub_busy  = 1'b0;
   bit          stub_hang  = 1'b0;
   bit          stub_force = 1'b0;
   int          stub_cnt   = 0;
   int          force_cos  = 0;
   int          force_sin  = 0;

   assign cordic_done = stub_done;
   assign cordic_cos  = stub_cos;
   assign cordic_sin  = stub_sin;

   always @(posedge clk) begin
      if (cordic_init) begin
         stub_busy <= 1'b1;
         stub_cnt  <= 0;
         stub_ang  <= cordic_angle;
      end else if (stub_busy) begin
         stub_cnt <= stub_cnt + 1;
         if (stub_cnt == 1) stub_done <= 1'b0;
         if (stub_cnt == STUB_LAT && !stub_hang) begin
            stub_done <= 1'b1;
            stub_busy <= 1'b0;
            if (stub_force) begin
               stub_cos <= 18'(force_cos);
               stub_sin <= 18'(force_sin);
            end else begin
               stub_cos <= q18($cos(real'(sx18(stub_ang)) / 65536.0));
               stub_sin <= q18($sin(real'(sx18(stub_ang)) / 65536.0));
            end
         end
      end
   end

   typedef struct { int c; int s; bit e; int tol; } exp_t;
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Drives one request from a negedge and returns the held result; leaves after the out handshake.
   task automatic run_req(input logic [18:0] a, input int bound,
                          output logic [17:0] ang, output logic [17:0] c, output logic [17:0] s,
                          output logic e, output int inits, output bit ok);
      int k;
      ok = 1'b0; inits = 0; ang = '0; c = '0; s = '0; e = 1'b0;
      in_valid = 1'b1;
      in_angle = a;
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (!in_ready) begin in_valid = 1'b0; return; end
      @(negedge clk);
      in_valid = 1'b0;
      ang = cordic_angle;
      for (int i = 0; i < bound; i++) begin
         if (cordic_init) inits++;
         if (out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) return;
      c = out_cos; s = out_sin; e = out_err;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, cordic_init, out_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset ctrl: ready/valid/init/err=%b want 0000", {in_ready, out_valid, cordic_init, out_err});
      end
      n_vec++;
      if (cordic_angle !== 18'd0 || out_cos !== 18'd0 || out_sin !== 18'd0) begin
         n_err++;
         $display("FAIL reset data: angle=%0d cos=%0d sin=%0d want 0", sx18(cordic_angle), sx18(out_cos), sx18(out_sin));
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset release: in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_fold;
      int ang_in [10] = '{0, 131072, -205887, 250000, 102944, 102945, -102944, -102945, -262144, 50000};
      int ang_exp[10] = '{0, -74815, 0, 0, 102944, -102942, -102944, 102942, 0, 50000};
      logic [17:0] ang, c, s;
      logic e;
      int inits, ca;
      bit ok;
      exp_t x;
      for (int i = 0; i < 10; i++) begin
         ca = clamp_pi(ang_in[i]);
         sb.push_back('{c: int'($cos(real'(ca) / 65536.0) * 65536.0),
                        s: int'($sin(real'(ca) / 65536.0) * 65536.0), e: 1'b0, tol: 16});
         run_req(19'(ang_in[i]), 200, ang, c, s, e, inits, ok);
         x = sb.pop_front();
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL fold[%0d] complete: no out_valid within bound", i); continue; end
         n_vec++;
         if (sx18(ang) !== ang_exp[i]) begin
            n_err++; $display("FAIL fold[%0d] cordic_angle: got %0d want %0d", i, sx18(ang), ang_exp[i]);
         end
         n_vec++;
         if (inits !== 1) begin n_err++; $display("FAIL fold[%0d] init pulses: got %0d want 1", i, inits); end
         n_vec++;
         if (absd(sx18(c), x.c) > x.tol) begin
            n_err++; $display("FAIL fold[%0d] cos: got %0d want %0d +-%0d", i, sx18(c), x.c, x.tol);
         end
         n_vec++;
         if (absd(sx18(s), x.s) > x.tol) begin
            n_err++; $display("FAIL fold[%0d] sin: got %0d want %0d +-%0d", i, sx18(s), x.s, x.tol);
         end
         n_vec++;
         if (e !== x.e) begin n_err++; $display("FAIL fold[%0d] err: got %b want %b", i, e, x.e); end
      end
   endtask

   task automatic test_hold;
      logic [17:0] c0, s0;
      int bad_valid = 0, bad_data = 0, bad_ready = 0, bad_init = 0;
      int ca = 40000;
      exp_t x;
      sb.push_back('{c: int'($cos(real'(ca) / 65536.0) * 65536.0),
                     s: int'($sin(real'(ca) / 65536.0) * 65536.0), e: 1'b0, tol: 16});
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_angle  = 19'(ca);
      for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold start: out_valid=%b want 1", out_valid); end
      c0 = out_cos; s0 = out_sin;
      in_valid = 1'b1;
      in_angle = 19'(-100000);
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b1) bad_valid++;
         if (out_cos !== c0 || out_sin !== s0) bad_data++;
         if (in_ready !== 1'b0) bad_ready++;
         if (cordic_init !== 1'b0) bad_init++;
      end
      n_vec++;
      if (bad_valid != 0) begin n_err++; $display("FAIL hold valid: dropped %0d cycles want 0", bad_valid); end
      n_vec++;
      if (bad_data != 0) begin n_err++; $display("FAIL hold data: changed %0d cycles want 0", bad_data); end
      n_vec++;
      if (bad_ready != 0) begin n_err++; $display("FAIL hold in_ready: high %0d cycles want 0", bad_ready); end
      n_vec++;
      if (bad_init != 0) begin n_err++; $display("FAIL hold init: %0d extra pulses want 0", bad_init); end
      x = sb.pop_front();
      n_vec++;
      if (absd(sx18(c0), x.c) > x.tol || absd(sx18(s0), x.s) > x.tol) begin
         n_err++; $display("FAIL hold result: cos=%0d sin=%0d want %0d %0d", sx18(c0), sx18(s0), x.c, x.s);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL hold release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back;
      int ang_in[3] = '{131072, -50000, 180000};
      logic [17:0] ang, c, s;
      logic e;
      int inits, ca;
      bit ok;
      exp_t x;
      for (int i = 0; i < 3; i++) begin
         ca = ang_in[i];
         sb.push_back('{c: int'($cos(real'(ca) / 65536.0) * 65536.0),
                        s: int'($sin(real'(ca) / 65536.0) * 65536.0), e: 1'b0, tol: 16});
         run_req(19'(ca), 200, ang, c, s, e, inits, ok);
         x = sb.pop_front();
         n_vec++;
         if (!ok || absd(sx18(c), x.c) > x.tol || absd(sx18(s), x.s) > x.tol) begin
            n_err++;
            $display("FAIL b2b[%0d] result: ok=%b cos=%0d sin=%0d want %0d %0d", i, ok, sx18(c), sx18(s), x.c, x.s);
         end
         n_vec++;
         if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] next ready: got %b want 1", i, in_ready); end
      end
   endtask

   task automatic test_saturation;
      int ang_in[3] = '{150000, -150000, 1000};
      int fc[3]     = '{-131072, 1000, -131072};
      int fs[3]     = '{131071, -131072, 131071};
      int ec[3]     = '{131071, -1000, -131072};
      int es[3]     = '{-131071, 131071, 131071};
      logic [17:0] ang, c, s;
      logic e;
      int inits;
      bit ok;
      exp_t x;
      stub_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         force_cos = fc[i];
         force_sin = fs[i];
         sb.push_back('{c: ec[i], s: es[i], e: 1'b0, tol: 0});
         run_req(19'(ang_in[i]), 200, ang, c, s, e, inits, ok);
         x = sb.pop_front();
         n_vec++;
         if (!ok || sx18(c) !== x.c || sx18(s) !== x.s) begin
            n_err++;
            $display("FAIL sat[%0d]: ok=%b cos=%0d sin=%0d want %0d %0d", i, ok, sx18(c), sx18(s), x.c, x.s);
         end
      end
      stub_force = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [17:0] ang, c, s;
      logic e;
      int inits;
      bit ok;
      exp_t x;
      in_valid = 1'b1;
      in_angle = 19'(60000);
      for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst busy: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, cordic_init} !== 3'b000 || cordic_angle !== 18'd0 ||
          out_cos !== 18'd0 || out_sin !== 18'd0) begin
         n_err++;
         $display("FAIL midrst clear: ready=%b valid=%b init=%b angle=%0d cos=%0d sin=%0d want all 0",
                  in_ready, out_valid, cordic_init, sx18(cordic_angle), sx18(out_cos), sx18(out_sin));
      end
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst held: in_ready=%b want 0", in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      sb.push_back('{c: int'($cos(2.0) * 65536.0), s: int'($sin(2.0) * 65536.0), e: 1'b0, tol: 16});
      run_req(19'(131072), 200, ang, c, s, e, inits, ok);
      x = sb.pop_front();
      n_vec++;
      if (!ok || sx18(ang) !== -74815 || absd(sx18(c), x.c) > x.tol || absd(sx18(s), x.s) > x.tol) begin
         n_err++;
         $display("FAIL midrst recover: ok=%b angle=%0d cos=%0d sin=%0d want -74815 %0d %0d",
                  ok, sx18(ang), sx18(c), sx18(s), x.c, x.s);
      end
   endtask

`ifdef CORDIC_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      logic [17:0] ang, c, s;
      logic e;
      int inits;
      bit ok;
      exp_t x;
      stub_hang = 1'b1;
      sb.push_back('{c: 0, s: 0, e: 1'b1, tol: 0});
      run_req(19'(70000), TMO + 40, ang, c, s, e, inits, ok);
      x = sb.pop_front();
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL timeout complete: no out_valid within %0d cycles", TMO + 40); end
      n_vec++;
      if (e !== x.e || sx18(c) !== x.c || sx18(s) !== x.s) begin
         n_err++; $display("FAIL timeout result: err=%b cos=%0d sin=%0d want 1 0 0", e, sx18(c), sx18(s));
      end
      stub_hang = 1'b0;
      sb.push_back('{c: int'($cos(0.5) * 65536.0), s: int'($sin(0.5) * 65536.0), e: 1'b0, tol: 16});
      run_req(19'(32768), 200, ang, c, s, e, inits, ok);
      x = sb.pop_front();
      n_vec++;
      if (!ok || e !== x.e || absd(sx18(c), x.c) > x.tol || absd(sx18(s), x.s) > x.tol) begin
         n_err++;
         $display("FAIL timeout recover: ok=%b err=%b cos=%0d sin=%0d want 0 %0d %0d", ok, e, sx18(c), sx18(s), x.c, x.s);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fold();
      test_hold();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
`ifdef CORDIC_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
